imm_enc: RTL and testbench

IMM_ENC -- requirements
Module: imm_enc

---
 rtl/imm_enc.sv | 173 +++++++++++++++++
 tb/tb_imm_enc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imm_enc.sv
// rtl/imm_enc.sv - instruction encoder with a one-entry output register; optional immediate range check under IMM_RANGE_CHECK_EN
module imm_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    // Opcode values that select each encoding format
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_U_LUI  = 7'b0110111;
    localparam logic [6:0] OP_U_AUI  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;

    // Word emitted for an opcode the encoder does not recognise (addi x0, x0, 0)
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_t;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    fmt_t        w_fmt;
    logic [31:0] w_instr;
    logic        w_op_err;
    logic        w_err;
    logic        w_in_ready;
    logic        w_accept;

    state_t      r_state;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_err;
    logic [15:0] r_enc_count;

    // Decode the opcode into one of the six formats or unknown
    always_comb begin
        w_fmt = FMT_X;
        case (in_op)
            OP_R:                            w_fmt = FMT_R;
            OP_I_ALU, OP_I_LOAD, OP_I_JALR:  w_fmt = FMT_I;
            OP_S:                            w_fmt = FMT_S;
            OP_B:                            w_fmt = FMT_B;
            OP_U_LUI, OP_U_AUI:              w_fmt = FMT_U;
            OP_J:                            w_fmt = FMT_J;
            default:                         w_fmt = FMT_X;
        endcase
    end

    // Pack the fields for the decoded format; immediates are truncated to the bits each format carries
    always_comb begin
        w_instr = NOP_WORD;
        case (w_fmt)
            FMT_R: w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            FMT_I: w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            FMT_S: w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            FMT_B: w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_op};
            FMT_U: w_instr = {in_imm[31:12], in_rd, in_op};
            FMT_J: w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            default: w_instr = NOP_WORD;
        endcase
    end

    assign w_op_err = (w_fmt == FMT_X);

`ifdef IMM_RANGE_CHECK_EN
    logic w_ok_12;
    logic w_ok_b;
    logic w_ok_j;
    logic w_ok_u;
    logic w_range_err;

    assign w_ok_12 = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
    assign w_ok_b  = (in_imm == {{19{in_imm[12]}}, in_imm[12:0]}) && !in_imm[0];
    assign w_ok_j  = (in_imm == {{11{in_imm[20]}}, in_imm[20:0]}) && !in_imm[0];
    assign w_ok_u  = (in_imm[11:0] == 12'h000);

    // Flag an immediate that the selected format cannot represent exactly
    always_comb begin
        w_range_err = 1'b0;
        case (w_fmt)
            FMT_I, FMT_S: w_range_err = !w_ok_12;
            FMT_B:        w_range_err = !w_ok_b;
            FMT_J:        w_range_err = !w_ok_j;
            FMT_U:        w_range_err = !w_ok_u;
            default:      w_range_err = 1'b0;
        endcase
    end

    assign w_err = w_op_err || w_range_err;
`else
    assign w_err = w_op_err;
`endif

    // A new word may enter whenever the register is empty or is being drained this cycle
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // Output register state machine and handshake counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h00000000;
            r_out_err   <= 1'b0;
            r_enc_count <= 16'h0000;
        end else begin
            if (r_out_valid && out_ready) begin
                r_enc_count <= r_enc_count + 16'd1;
            end
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                        r_out_instr <= w_instr;
                        r_out_err   <= w_err;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                        r_out_instr <= w_instr;
                        r_out_err   <= w_err;
                    end else if (out_ready) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign enc_count = r_enc_count;

endmodule

// File: tb/tb_imm_enc.sv
// tb/tb_imm_enc.sv - directed-vector self-checking bench for imm_enc
module tb_imm_enc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;

    int n_vec;
    int n_err;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    imm_enc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_funct3 (in_funct3),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_funct3 = f3;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // One word in, check it, then drain it with out_ready=1
    task automatic single(input string tag, input logic [6:0] op, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
        drive(op, rd, f3, rs1, rs2, f7, imm);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        step();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = 7'd0;
        in_rd     = 5'd0;
        in_funct3 = 3'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct7 = 7'd0;
        in_imm    = 32'd0;

        // Reset state
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_count", {16'd0, enc_count}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // I-type with all-ones immediate, latency one cycle
        single("i_neg1", 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        check("i_neg1_count", {16'd0, enc_count}, 32'd1);
        check("i_neg1_drained", {31'd0, out_valid}, 32'd0);

        // S, B, J back to back with out_ready held high
        out_ready = 1'b1;
        drive(7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        step();
        check("s_instr", out_instr, 32'h0020A423);
        drive(7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC);
        step();
        check("b_instr", out_instr, 32'hFE000EE3);
        check("b_valid", {31'd0, out_valid}, 32'd1);
        drive(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        step();
        check("j_instr", out_instr, 32'h001000EF);
        check("j_err", {31'd0, out_err}, 32'd0);
        in_valid = 1'b0;
        step();
        check("sbj_count", {16'd0, enc_count}, 32'd4);

        // Other formats, unknown opcode and range boundaries
        single("r_sub", 7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'h0, 32'h403100B3, 1'b0);
        single("unk_op", 7'b1111111, 5'd7, 3'd5, 5'd9, 5'd4, 7'h11, 32'h1234, 32'h00000013, 1'b1);
        single("i_2048", 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h80000093, RC);
        single("i_m2048", 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        single("u_low", 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345678, 32'h123452B7, RC);
        single("u_ok", 7'b0010111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 32'h12345297, 1'b0);
        single("b_odd", 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 32'h00000163, RC);
        check("vec_count", {16'd0, enc_count}, 32'd11);

        // Backpressure: word held, new request blocked, then replaced on release
        out_ready = 1'b0;
        drive(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        step();
        check("bp_first", out_instr, 32'h00500113);
        drive(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_instr", out_instr, 32'h00500113);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_count", {16'd0, enc_count}, 32'd11);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_replace_instr", out_instr, 32'h00700193);
        check("bp_replace_valid", {31'd0, out_valid}, 32'd1);
        check("bp_replace_count", {16'd0, enc_count}, 32'd12);

        // Reset while FULL and stalled
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {16'd0, enc_count}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("mid_rst_stay_empty", {31'd0, out_valid}, 32'd0);

        // Counter wrap: 65536 handshakes
        out_ready = 1'b1;
        drive(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        repeat (65536) step();
        check("wrap_ffff", {16'd0, enc_count}, 32'h0000FFFF);
        in_valid = 1'b0;
        step();
        check("wrap_zero", {16'd0, enc_count}, 32'd0);
        check("wrap_empty", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
